// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//
// Contents:
//   DEF_WIDTH, DEF_BITS_PER_CYCLE - default parameter values for the top
//   state_e                       - controller state encoding (IDLE/RUN/DONE)
//   params_ok()                   - elaboration-time legality check of the
//                                   WIDTH / BITS_PER_CYCLE pair
//   counter_width()               - step counter width, never below one bit

package serial_add_sub_pkg;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_BITS_PER_CYCLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The digit must tile the operand exactly; a partial last digit would
    // need a separate datapath, which this block does not have.
    function automatic bit params_ok(input int width, input int bits_per_cycle);
        return (width >= 2) && (bits_per_cycle >= 1) &&
               (bits_per_cycle <= width) && ((width % bits_per_cycle) == 0);
    endfunction

    // A single-step configuration still needs a 1-bit counter to exist.
    function automatic int counter_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the digit ripple chain.
//
// Ports:
//   x, y : input  1  operand bits
//   c    : input  1  carry in
//   s    : output 1  sum bit        (x ^ y ^ c)
//   co   : output 1  carry out      (majority of x, y, c)

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ c;
    assign co = (x & y) | (x & c) | (y & c);

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor. Operands are accepted over a valid/ready
// handshake, processed BITS_PER_CYCLE bits per clock LSB first through a
// ripple chain of full adders, and the result is offered over a second
// valid/ready handshake. Subtraction is a + ~b + ~cin.
//
// Parameters:
//   WIDTH          operand/result width (>= 2)
//   BITS_PER_CYCLE bits per clock, must divide WIDTH
//
// Ports:
//   clk       : input  1      clock
//   rst       : input  1      synchronous active-high reset
//   in_valid  : input  1      operands present
//   in_ready  : output 1      block can accept operands (IDLE only)
//   a, b      : input  WIDTH  operands
//   sub       : input  1      0 = add, 1 = subtract
//   cin       : input  1      carry-in (add) / borrow-in (subtract)
//   out_valid : output 1      result present (DONE only)
//   out_ready : input  1      consumer takes result
//   sum       : output WIDTH  result (partial while running)
//   cout      : output 1      carry out of MSB (subtract: 1 = no borrow)
//   ovf       : output 1      two's-complement overflow
//   busy      : output 1      high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit per clock through the ripple chain
// DONE  | result held on the outputs until out_ready

module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = counter_width(STEPS);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_param_check
        $error("serial_add_sub: BITS_PER_CYCLE=%0d must divide WIDTH=%0d (WIDTH >= 2)",
               BITS_PER_CYCLE, WIDTH);
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             cout_r;
    logic             ovf_r;

    // chain_c[i] is the carry into cell i; chain_c[BITS_PER_CYCLE] leaves
    // the digit. On the last step, cell BITS_PER_CYCLE-1 holds the operand
    // MSB, so its carry-in and carry-out give the overflow term.
    logic [BITS_PER_CYCLE:0]   chain_c;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic                      msb_carry_in;
    logic                      chain_co;

    assign chain_c[0] = carry;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
        full_adder u_fa (
            .x  (a_sh[i]),
            .y  (b_sh[i]),
            .c  (chain_c[i]),
            .s  (digit[i]),
            .co (chain_c[i+1])
        );
    end

    assign msb_carry_in = chain_c[BITS_PER_CYCLE-1];
    assign chain_co     = chain_c[BITS_PER_CYCLE];

    // Digits enter at the MSB end so that after STEPS shifts the first
    // digit has travelled down to bit 0.
    if (STEPS == 1) begin : g_sum_single
        assign sum_next = digit;
    end else begin : g_sum_shift
        assign sum_next = {digit, sum_r[WIDTH-1:BITS_PER_CYCLE]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        // Borrow-in inverts to a carry-in when subtracting.
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= sum_next;
                    a_sh  <= a_sh >> BITS_PER_CYCLE;
                    b_sh  <= b_sh >> BITS_PER_CYCLE;
                    carry <= chain_co;
                    if (cnt == LAST_STEP) begin
                        cout_r <= chain_co;
                        ovf_r  <= msb_carry_in ^ chain_co;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: one instance with one bit per cycle,
// one with four bits per cycle, randomized operands against an arithmetic
// reference model.

module tb_serial_add_sub;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid0, in_ready0, sub0, cin0, out_valid0, out_ready0, cout0, ovf0, busy0;
    logic [W-1:0] a0, b0, sum0;
    logic         in_valid1, in_ready1, sub1, cin1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [W-1:0] a1, b1, sum1;

    serial_add_sub #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .sub(sub0), .cin(cin0), .out_valid(out_valid0),
        .out_ready(out_ready0), .sum(sum0), .cout(cout0), .ovf(ovf0), .busy(busy0)
    );

    serial_add_sub #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1), .cin(cin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c);
        exp_t   e;
        longint ua, ub, sa, sb, cc, r, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cc = longint'(c);
        if (!s) begin
            r      = ua + ub + cc;
            e.cout = (r >= (longint'(1) << W));
            sr     = sa + sb + cc;
        end else begin
            r      = ua - ub - cc;
            e.cout = (ua >= ub + cc);
            sr     = sa - sb - cc;
        end
        e.sum = W'(r);
        e.ovf = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected result: got sum 0x%0h, expected no result", sum0);
            end else begin
                e0 = q0.pop_front();
                chk("dut0 sum", sum0, e0.sum);
                chk("dut0 cout", cout0, e0.cout);
                chk("dut0 ovf", ovf0, e0.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected result: got sum 0x%0h, expected no result", sum1);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 sum", sum1, e1.sum);
                chk("dut1 cout", cout1, e1.cout);
                chk("dut1 ovf", ovf1, e1.ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present operands, wait for acceptance, push the expectation and
    // measure cycles from the accepting edge until out_valid.
    task automatic issue(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c);
        int   n;
        int   steps;
        logic rdy;
        steps = (d == 0) ? W : W / 4;
        tick();
        if (d == 0) begin
            in_valid0 = 1'b1; a0 = a; b0 = b; sub0 = s; cin0 = c;
        end else begin
            in_valid1 = 1'b1; a1 = a; b1 = b; sub1 = s; cin1 = c;
        end
        n = 0;
        rdy = 1'b0;
        forever begin
            @(negedge clk);
            rdy = (d == 0) ? in_ready0 : in_ready1;
            if (rdy || n > 50) break;
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL dut%0d accept timeout: in_ready got 0, expected 1", d);
            in_valid0 = 1'b0;
            in_valid1 = 1'b0;
            return;
        end
        @(posedge clk);
        #2;
        if (d == 0) begin
            in_valid0 = 1'b0;
            q0.push_back(model(a, b, s, c));
        end else begin
            in_valid1 = 1'b0;
            q1.push_back(model(a, b, s, c));
        end
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (((d == 0) ? out_valid0 : out_valid1) || n > 40) break;
        end
        chk($sformatf("dut%0d latency", d), n, steps);
    endtask

    task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input int hold);
        if (d == 0) out_ready0 = (hold == 0);
        else        out_ready1 = (hold == 0);
        issue(d, a, b, s, c);
        if (hold > 0) begin
            repeat (hold) tick();
            if (d == 0) out_ready0 = 1'b1;
            else        out_ready1 = 1'b1;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t bp;
        logic seen;

        rst = 1'b1;
        in_valid0 = 0; a0 = '0; b0 = '0; sub0 = 0; cin0 = 0; out_ready0 = 1;
        in_valid1 = 0; a1 = '0; b1 = '0; sub1 = 0; cin1 = 0; out_ready1 = 1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", in_ready0, 1);
        chk("reset out_valid", out_valid0, 0);
        chk("reset busy", busy0, 0);
        chk("reset sum", sum0, 0);
        chk("reset cout", cout0, 0);
        chk("reset ovf", ovf0, 0);
        chk("reset dut1 in_ready", in_ready1, 1);

        run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(0, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
        run_op(0, 8'h10, 8'h20, 1'b1, 1'b0, 2);
        run_op(0, 8'h80, 8'h00, 1'b1, 1'b1, 0);

        // Backpressure: result must hold while new operands are offered.
        bp = model(8'hC3, 8'h5E, 1'b0, 1'b1);
        out_ready0 = 1'b0;
        issue(0, 8'hC3, 8'h5E, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            in_valid0 = 1'b1;
            a0 = W'($urandom);
            b0 = W'($urandom);
            sub0 = 1'($urandom);
            @(negedge clk);
            chk("bp out_valid", out_valid0, 1);
            chk("bp in_ready", in_ready0, 0);
            chk("bp busy", busy0, 1);
            chk("bp sum", sum0, bp.sum);
            chk("bp cout", cout0, bp.cout);
            chk("bp ovf", ovf0, bp.ovf);
        end
        tick();
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        tick();
        @(negedge clk);
        chk("bp release out_valid", out_valid0, 0);
        chk("bp release in_ready", in_ready0, 1);

        // Reset during RUN aborts the operation silently.
        tick();
        in_valid0 = 1'b1; a0 = 8'h37; b0 = 8'h19; sub0 = 1'b0; cin0 = 1'b0;
        @(negedge clk);
        chk("abort accept ready", in_ready0, 1);
        @(posedge clk);
        #2 in_valid0 = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort in_ready", in_ready0, 1);
        chk("abort out_valid", out_valid0, 0);
        chk("abort busy", busy0, 0);
        chk("abort sum", sum0, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid0) seen = 1'b1;
        end
        chk("abort never valid", seen, 0);
        run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            run_op(0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        run_op(1, 8'h0F, 8'h01, 1'b0, 1'b0, 0);
        run_op(1, 8'h80, 8'h00, 1'b1, 1'b1, 1);
        for (int i = 0; i < 15; i++) begin
            run_op(1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        repeat (3) tick();
        chk("dut0 queue drained", q0.size(), 0);
        chk("dut1 queue drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
